// File: rtl/p2s_tx_scheduler.sv
// p2s_tx_scheduler: round-robin arbiter that loads one requester's word into a
// shared parallel-to-serial converter and flags each serial bit it produces.
module p2s_tx_scheduler #(
    parameter int N       = 4,
    parameter int NUM_REQ = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [NUM_REQ*N-1:0]       i_data,
    input  logic [NUM_REQ-1:0]         i_dir,
    output logic [NUM_REQ-1:0]         o_ack,
    output logic                       o_p2s_valid,
    output logic                       o_p2s_direction,
    output logic [N-1:0]               o_p2s_data,
    output logic                       o_bit_valid,
    output logic                       o_last,
    output logic                       o_busy,
    output logic [$clog2(NUM_REQ)-1:0] o_owner
);
    localparam int OW = $clog2(NUM_REQ);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [OW-1:0]   ptr_q, ptr_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [N-1:0]    word_q, word_d;
    logic            dir_q, dir_d;
    logic            found, last;
    logic [OW-1:0]   win, cand;
    logic [N-1:0]    win_word;

    // First asserted request after the pointer; the last winner ranks lowest.
    always_comb begin
        found    = 1'b0;
        win      = '0;
        cand     = '0;
        win_word = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = OW'((int'(ptr_q) + k) % NUM_REQ);
            if (!found && i_req[cand]) begin
                found    = 1'b1;
                win      = cand;
                win_word = i_data[int'(cand)*N +: N];
            end
        end
    end

    assign last = (state_q == SHIFT) && (cnt_q == CW'(N-1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        word_d  = word_q;
        dir_d   = dir_q;
        if (found && (state_q == IDLE || last)) begin
            state_d = LOAD;
            ptr_d   = win;
            owner_d = win;
            word_d  = win_word;
            dir_d   = i_dir[win];
        end else if (state_q == LOAD) begin
            state_d = SHIFT;
            cnt_d   = '0;
        end else if (state_q == SHIFT) begin
            state_d = last ? IDLE : SHIFT;
            cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= OW'(NUM_REQ-1);
            owner_q <= '0;
            word_q  <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            word_q  <= word_d;
            dir_q   <= dir_d;
        end
    end

    assign o_ack           = (state_q == LOAD) ? NUM_REQ'(1) << owner_q : '0;
    assign o_p2s_valid     = (state_q == LOAD);
    assign o_p2s_data      = (state_q == LOAD) ? word_q : '0;
    assign o_p2s_direction = dir_q;
    assign o_bit_valid     = (state_q == SHIFT);
    assign o_last          = last;
    assign o_busy          = (state_q != IDLE);
    assign o_owner         = owner_q;
endmodule

// File: tb/tb_p2s_tx_scheduler.sv
// tb_p2s_tx_scheduler: directed checks of arbitration order, load/shift timing
// and bit order, using a small converter model fed by the scheduler outputs.
module tb_p2s_tx_scheduler;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req = '0;
    logic [7:0] data = '0;
    logic [1:0] dir = '0;
    logic [1:0] ack;
    logic       p2s_valid, p2s_dir, bit_valid, last, busy;
    logic [3:0] p2s_data;
    logic       owner;
    logic [3:0] sh = '0;
    int         bi = 0;
    int         n_asserts = 0;
    int         n_fail = 0;
    logic       ser;

    p2s_tx_scheduler #(.N(4), .NUM_REQ(2)) dut (
        .clk(clk), .rst(rst_n), .i_req(req), .i_data(data), .i_dir(dir),
        .o_ack(ack), .o_p2s_valid(p2s_valid), .o_p2s_direction(p2s_dir),
        .o_p2s_data(p2s_data), .o_bit_valid(bit_valid), .o_last(last),
        .o_busy(busy), .o_owner(owner)
    );

    always #5 clk = ~clk;

    // Converter model: captures on valid, emits one bit per shift cycle.
    always @(posedge clk) begin
        if (p2s_valid) begin
            sh <= p2s_data;
            bi <= 0;
        end else if (bit_valid) begin
            bi <= bi + 1;
        end
    end
    assign ser = p2s_dir ? sh[bi[1:0]] : sh[3 - bi[1:0]];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_load(input logic own, input logic [3:0] word, input logic d);
        chk("load_ack", ack, own ? 2'b10 : 2'b01);
        chk("load_valid", p2s_valid, 1);
        chk("load_data", p2s_data, word);
        chk("load_dir", p2s_dir, d);
        chk("load_owner", owner, own);
        chk("load_busy", busy, 1);
        chk("load_bitvalid", bit_valid, 0);
    endtask

    task automatic check_bit(input int i, input logic [3:0] bits, input logic d);
        tick();
        chk("shift_bitvalid", bit_valid, 1);
        chk("shift_serial", ser, bits[3-i]);
        chk("shift_last", last, i == 3);
        chk("shift_dir", p2s_dir, d);
        chk("shift_ack", ack, 0);
        chk("shift_p2svalid", p2s_valid, 0);
        chk("shift_data", p2s_data, 0);
        chk("shift_busy", busy, 1);
    endtask

    task automatic check_shift(input logic [3:0] bits, input logic d);
        for (int i = 0; i < 4; i++) check_bit(i, bits, d);
    endtask

    task automatic check_idle(input logic d);
        chk("idle_busy", busy, 0);
        chk("idle_bitvalid", bit_valid, 0);
        chk("idle_ack", ack, 0);
        chk("idle_dir_hold", p2s_dir, d);
    endtask

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_ack", ack, 0);
        chk("rst_valid", p2s_valid, 0);
        chk("rst_data", p2s_data, 0);
        chk("rst_dir", p2s_dir, 0);
        chk("rst_owner", owner, 0);
        chk("rst_last", last, 0);
        // Single word, MSB first from requester 0
        rst_n = 1'b1;
        req = 2'b01; data = 8'h0B; dir = 2'b00;
        chk("cycle0_busy", busy, 0);
        tick();
        check_load(1'b0, 4'b1011, 1'b0);
        req = 2'b00;
        check_shift(4'b1011, 1'b0);
        tick();
        check_idle(1'b0);
        // Single word, LSB first from requester 1
        req = 2'b10; data = 8'hB0; dir = 2'b10;
        tick();
        check_load(1'b1, 4'b1011, 1'b1);
        req = 2'b00;
        check_shift(4'b1101, 1'b1);
        tick();
        check_idle(1'b1);
        // Contention: back-to-back alternating grants
        req = 2'b11; data = 8'b0110_1100; dir = 2'b10;
        tick();
        check_load(1'b0, 4'b1100, 1'b0);
        check_shift(4'b1100, 1'b0);
        tick();
        check_load(1'b1, 4'b0110, 1'b1);
        check_shift(4'b0110, 1'b1);
        tick();
        check_load(1'b0, 4'b1100, 1'b0);
        check_shift(4'b1100, 1'b0);
        tick();
        check_load(1'b1, 4'b0110, 1'b1);
        req = 2'b00;
        check_shift(4'b0110, 1'b1);
        tick();
        check_idle(1'b1);
        // Late arrival during SHIFT, then post-grant data change and withdrawn pulse
        req = 2'b01; data = 8'h03; dir = 2'b00;
        tick();
        check_load(1'b0, 4'b0011, 1'b0);
        req = 2'b00;
        check_bit(0, 4'b0011, 1'b0);
        check_bit(1, 4'b0011, 1'b0);
        req = 2'b10; data = 8'h93;
        check_bit(2, 4'b0011, 1'b0);
        check_bit(3, 4'b0011, 1'b0);
        tick();
        check_load(1'b1, 4'b1001, 1'b0);
        req = 2'b00; data = 8'h03;
        check_bit(0, 4'b1001, 1'b0);
        req = 2'b01;
        check_bit(1, 4'b1001, 1'b0);
        req = 2'b00;
        check_bit(2, 4'b1001, 1'b0);
        check_bit(3, 4'b1001, 1'b0);
        tick();
        check_idle(1'b0);
        // Reset mid-word, then requester 0 wins first after release
        req = 2'b01; data = 8'h5A; dir = 2'b00;
        tick();
        check_load(1'b0, 4'b1010, 1'b0);
        req = 2'b11;
        check_bit(0, 4'b1010, 1'b0);
        check_bit(1, 4'b1010, 1'b0);
        check_bit(2, 4'b1010, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_bitvalid", bit_valid, 0);
        chk("midrst_last", last, 0);
        chk("midrst_ack", ack, 0);
        chk("midrst_valid", p2s_valid, 0);
        chk("midrst_data", p2s_data, 0);
        tick();
        rst_n = 1'b1;
        chk("postrst_busy", busy, 0);
        tick();
        check_load(1'b0, 4'b1010, 1'b0);
        req = 2'b00;
        check_shift(4'b1010, 1'b0);
        tick();
        check_idle(1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule

// File: doc/p2s_tx_scheduler.md
Name: p2s_tx_scheduler

Overview:
- Round-robin controller that shares one parallel_to_serial_converter instance among NUM_REQ requesters.
- Selects one requester, loads its N-bit word into the converter, and holds the shift direction stable for N shift cycles.
- Flags each valid serial bit and the last bit of each word.
- Sits between the word producers and the converter. Its o_p2s_* outputs connect directly to the converter's i_valid, direction and i_data inputs.

Parameters:
- N, 4, word width. Must match the converter's N. N >= 2.
- NUM_REQ, 2, number of requesters. NUM_REQ >= 2.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset.
- i_req  input  NUM_REQ  request k asserted while requester k has a word pending.
- i_data  input  NUM_REQ*N  requester k's word at [k*N +: N].
- i_dir  input  NUM_REQ  per-requester direction: 0 = MSB_FIRST, 1 = LSB_FIRST.
- o_ack  output  NUM_REQ  one-hot, one-cycle pulse when requester k's word is loaded.
- o_p2s_valid  output  1  to converter i_valid.
- o_p2s_direction  output  1  to converter direction.
- o_p2s_data  output  N  to converter i_data.
- o_bit_valid  output  1  converter out carries a valid serial bit this cycle.
- o_last  output  1  current serial bit is the final bit of the word.
- o_busy  output  1  high in LOAD or SHIFT.
- o_owner  output  $clog2(NUM_REQ)  index of the requester currently being served.

Behaviour:
- Reset (rst low, async):
  - state = IDLE; bit counter = 0; round-robin pointer = NUM_REQ-1, so requester 0 has top priority after reset.
  - Latched word, direction and owner cleared to 0.
  - All outputs 0.
  - Release is synchronous to clk; first arbitration happens on the first posedge with rst high.
- All outputs are decoded from registered state only; there are no combinational paths from inputs to outputs.
- State IDLE:
  - o_busy = 0.
  - If any i_req is high: choose the first asserted index searching pointer+1, pointer+2, ... modulo NUM_REQ.
  - Latch that requester's i_data slice, i_dir bit and index; set pointer = index; go to LOAD.
  - If no request, stay in IDLE.
- State LOAD (exactly 1 cycle):
  - o_p2s_valid = 1; o_p2s_data = latched word; o_p2s_direction = latched dir; o_ack[owner] = 1.
  - Converter captures the word on this cycle's closing edge.
  - Next state SHIFT; counter = 0.
- State SHIFT (exactly N cycles):
  - o_p2s_valid = 0; o_p2s_data = 0; o_p2s_direction = latched dir, held constant.
  - o_bit_valid = 1; counter increments by 1 per cycle.
  - o_last = 1 when counter == N-1.
  - On the last cycle, arbitrate exactly as in IDLE. If a winner exists, go straight to LOAD (back-to-back, no IDLE cycle); otherwise go to IDLE.
- Outside SHIFT, o_p2s_direction holds its last value; after reset it is 0.
- Latency and throughput:
  - Request seen in IDLE at cycle t → LOAD/ack at t+1 → serial bits at t+2 .. t+N+1.
  - Sustained throughput is one word per N+1 cycles.
- Requester protocol:
  - Hold i_req, i_data and i_dir stable until o_ack.
  - The word is latched at the grant edge, so later changes are ignored.
  - i_req may drop the cycle after o_ack. If still high, it is a new word and competes normally.
  - A request withdrawn before it is sampled is never acked.
  - A new request arriving during SHIFT waits until the last SHIFT cycle.
- Simultaneous requests are resolved by the round-robin order only. The just-served requester has lowest priority next.
- Reset mid-operation:
  - The word is abandoned with no ack replay; outputs go to 0 immediately.
  - The converter is reset separately by its own rst.
- Counter width is $clog2(N). No wrap occurs beyond N-1, because the state leaves SHIFT.

Test Plan:
- Single word, MSB first: N=4; i_req[0] held from cycle 0 with data 4'b1011, dir 0 → o_ack[0] at cycle 1; o_bit_valid cycles 2-5; converter out 1,0,1,1; o_last at cycle 5; IDLE at cycle 6.
- Single word, LSB first: same word 4'b1011, dir 1 → out 1,1,0,1; o_p2s_direction = 1 through cycles 1-5.
- Contention: i_req = 2'b11 held continuously, words A and B → grants 0,1,0,1; LOADs at cycles 1,6,11,16; no IDLE cycle between words; o_owner alternates.
- Late arrival: req0 served; req1 rises during SHIFT bit 1 → req1 LOAD in the cycle immediately after req0's o_last; req1's data unchanged on out.
- Reset mid-word: rst low during SHIFT bit 2 → all outputs 0 within the same cycle, no clock needed. After release with i_req = 2'b11 → requester 0 granted first.
- Withdrawn and stable-hold checks: i_req[1] pulsed for 1 cycle while busy → never acked. i_data of an acked requester changed after grant → serialized bits still match the grant-time value.
